// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, constants and sigma helpers.
// Used by the message scheduler and the hash core.
package sha256_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam word_t H0 = 32'h6a09e667;
    localparam word_t H1 = 32'hbb67ae85;
    localparam word_t H2 = 32'h3c6ef372;
    localparam word_t H3 = 32'ha54ff53a;
    localparam word_t H4 = 32'h510e527f;
    localparam word_t H5 = 32'h9b05688c;
    localparam word_t H6 = 32'h1f83d9ab;
    localparam word_t H7 = 32'h5be0cd19;

    function automatic word_t rotr(word_t x, int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t ssig0(word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t ssig1(word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_msg_sched.sv
// SHA-256 message scheduler: accepts a padded block, pulses start,
// then streams W0..W63 from a 16-word sliding window.
module sha256_msg_sched
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         blk_valid_i,
    input  logic [511:0] blk_data_i,
    output logic         blk_ready_o,
    output logic         start_o,
    output logic [31:0]  wt_o,
    output logic         wt_valid_o,
    output logic [5:0]   round_o,
    output logic         last_o
);

    state_t     state;
    state_t     state_n;
    word_t      w [16];
    word_t      w_nxt;
    logic [5:0] cnt;
    logic       run;

    // W[t+16] = s1(W[t+14]) + W[t+9] + s0(W[t+1]) + W[t], with w[0] = W[t]
    assign w_nxt = ssig1(w[14]) + w[9] + ssig0(w[1]) + w[0];

    assign run         = (state == RUN);
    assign blk_ready_o = (state == IDLE);
    assign start_o     = (state == LOAD);
    assign wt_valid_o  = run;
    assign wt_o        = run ? w[0] : '0;
    assign round_o     = run ? cnt : '0;
    assign last_o      = run && (cnt == 6'd63);

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (blk_valid_i) state_n = LOAD;
            LOAD: state_n = RUN;
            RUN:  if (cnt == 6'd63) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Window load/shift and round counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            for (int i = 0; i < 16; i++) begin
                w[i] <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (blk_valid_i) begin
                        for (int i = 0; i < 16; i++) begin
                            w[i] <= blk_data_i[511 - 32*i -: 32];
                        end
                    end
                end
                LOAD: begin
                    cnt <= '0;
                end
                RUN: begin
                    for (int i = 0; i < 15; i++) begin
                        w[i] <= w[i+1];
                    end
                    w[15] <= w_nxt;
                    cnt   <= (cnt == 6'd63) ? 6'd0 : cnt + 6'd1;
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Scoreboard bench for sha256_msg_sched: reference expansion,
// cycle timing model, and a software compression of the abc stream.
module tb_sha256_msg_sched;
    import sha256_pkg::*;

    logic         clk;
    logic         rst_n;
    logic         blk_valid_i;
    logic [511:0] blk_data_i;
    logic         blk_ready_o;
    logic         start_o;
    logic [31:0]  wt_o;
    logic         wt_valid_o;
    logic [5:0]   round_o;
    logic         last_o;

    sha256_msg_sched dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .blk_valid_i (blk_valid_i),
        .blk_data_i  (blk_data_i),
        .blk_ready_o (blk_ready_o),
        .start_o     (start_o),
        .wt_o        (wt_o),
        .wt_valid_o  (wt_valid_o),
        .round_o     (round_o),
        .last_o      (last_o)
    );

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [511:0] ABC = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [255:0] ABC_HASH =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

    int    n_chk = 0;
    int    n_err = 0;
    word_t q [$];
    word_t ref_w [64];
    word_t cap [64];
    int    ph = 0;
    int    cyc = 0;
    int    acc_prev = 0;
    int    acc_last = 0;
    int    vcount = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic word_t ror(word_t x, int n);
        word_t r;
        r = x;
        for (int i = 0; i < n; i++) r = {r[0], r[31:1]};
        return r;
    endfunction

    function automatic void expand(input logic [511:0] b);
        for (int i = 0; i < 16; i++) ref_w[i] = b[511 - 32*i -: 32];
        for (int t = 16; t < 64; t++) begin
            ref_w[t] = (ror(ref_w[t-2], 17) ^ ror(ref_w[t-2], 19)
                        ^ (ref_w[t-2] >> 10))
                     + ref_w[t-7]
                     + (ror(ref_w[t-15], 7) ^ ror(ref_w[t-15], 18)
                        ^ (ref_w[t-15] >> 3))
                     + ref_w[t-16];
        end
    endfunction

    function automatic logic [255:0] compress_cap();
        word_t a, b, c, d, e, f, g, h, t1, t2;
        a = H0; b = H1; c = H2; d = H3;
        e = H4; f = H5; g = H6; h = H7;
        for (int t = 0; t < 64; t++) begin
            t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25))
                   + ((e & f) ^ (~e & g)) + K[t] + cap[t];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22))
                   + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        return {a + H0, b + H1, c + H2, d + H3,
                e + H4, f + H5, g + H6, h + H7};
    endfunction

    // Monitor: compare outputs to the timing model, then advance it
    initial begin
        word_t exp_w;
        @(posedge clk);
        forever begin
            @(negedge clk);
            cyc++;
            chk("ready", 256'(blk_ready_o), 256'(ph == 0));
            chk("start", 256'(start_o), 256'(ph == 1));
            chk("valid", 256'(wt_valid_o), 256'(ph >= 2));
            if (ph >= 2) begin
                vcount++;
                exp_w = (q.size() > 0) ? q.pop_front() : 32'hdeadbeef;
                chk("wt", 256'(wt_o), 256'(exp_w));
                chk("round", 256'(round_o), 256'(ph - 2));
                chk("last", 256'(last_o), 256'(ph == 65));
                cap[round_o] = wt_o;
            end else begin
                chk("round_idle", 256'(round_o), 256'(0));
                chk("last_idle", 256'(last_o), 256'(0));
            end
            if (!rst_n) begin
                ph = 0;
                q.delete();
            end else if (ph == 0 && blk_valid_i) begin
                expand(blk_data_i);
                for (int i = 0; i < 64; i++) q.push_back(ref_w[i]);
                acc_prev = acc_last;
                acc_last = cyc;
                ph = 1;
            end else if (ph == 65) begin
                ph = 0;
            end else if (ph > 0) begin
                ph++;
            end
        end
    end

    task automatic wait_acc();
        int  k;
        bit  ok;
        k  = 0;
        ok = 1'b0;
        while (k < 300 && !ok) begin
            @(negedge clk);
            if (blk_ready_o && rst_n) ok = 1'b1;
            @(posedge clk);
            #1;
            k++;
        end
        chk("accept_timeout", 256'(ok), 256'(1));
    endtask

    task automatic send(input logic [511:0] d, input int gap);
        blk_valid_i = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
        blk_data_i  = d;
        blk_valid_i = 1'b1;
        wait_acc();
        blk_valid_i = 1'b0;
    endtask

    task automatic drain();
        repeat (70) @(posedge clk);
        #1;
        chk("q_empty", 256'(q.size()), 256'(0));
    endtask

    initial begin
        logic [511:0] rb;
        logic [511:0] blk_b;
        int           vc0;
        bit           seen;
        int           k;

        rst_n       = 1'b0;
        blk_valid_i = 1'b1;
        blk_data_i  = ABC;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 256'(blk_ready_o), 256'(1));
        chk("rst_start", 256'(start_o), 256'(0));
        chk("rst_wt", 256'(wt_o), 256'(0));
        rst_n       = 1'b1;
        blk_valid_i = 1'b0;
        @(posedge clk);
        #1;

        send(ABC, 1);
        drain();
        chk("abc_w0", 256'(cap[0]), 256'(32'h61626380));
        chk("abc_w15", 256'(cap[15]), 256'(32'h00000018));
        chk("abc_w16", 256'(cap[16]), 256'(32'h61626380));
        chk("abc_w17", 256'(cap[17]), 256'(32'h000f0000));
        chk("abc_w18", 256'(cap[18]), 256'(32'h7da86405));
        chk("abc_w19", 256'(cap[19]), 256'(32'h600003c6));
        chk("abc_hash", compress_cap(), ABC_HASH);

        blk_b = {16{32'h0f1e2d3c}} ^ {ABC[255:0], ABC[511:256]};
        vc0 = vcount;
        blk_data_i  = ABC ^ {16{32'ha5a5a5a5}};
        blk_valid_i = 1'b1;
        wait_acc();
        blk_data_i  = blk_b;
        wait_acc();
        blk_valid_i = 1'b0;
        drain();
        chk("b2b_gap", 256'(acc_last - acc_prev), 256'(66));
        chk("b2b_count", 256'(vcount - vc0), 256'(128));

        send(ABC, 0);
        seen = 1'b0;
        k = 0;
        while (k < 200 && !seen) begin
            @(negedge clk);
            if (wt_valid_o && round_o == 6'd29) seen = 1'b1;
            k++;
        end
        chk("reach_r29", 256'(seen), 256'(1));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("mid_rst_idle", 256'(blk_ready_o), 256'(1));
        chk("mid_rst_valid", 256'(wt_valid_o), 256'(0));
        repeat (5) @(posedge clk);
        #1;
        send(ABC, 2);
        drain();
        chk("abc2_hash", compress_cap(), ABC_HASH);

        for (int n = 0; n < 200; n++) begin
            for (int i = 0; i < 16; i++) rb[32*i +: 32] = $urandom;
            send(rb, $urandom_range(0, 5));
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
